chip8_exec_core: RTL and testbench
==================================

Name: chip8_exec_core

Overview:
- Multi-cycle Chip-8 execution core. Successor to the single-cycle combinational decoder.
- Owns the PC, I register, V0-VF register file, call stack and delay timer.
- Fetches 16-bit instructions over a valid handshake and executes the non-display, non-keypad opcode subset.
- Sits between program memory and the future display/keypad units. Unsupported opcodes are flagged for those units and skipped.

Parameters:
ADDR_WIDTH, 12, width of PC, I and instr_addr; all address arithmetic wraps modulo 2^ADDR_WIDTH
STACK_DEPTH, 16, number of return-address entries (power of 2, >=2)
PC_RESET, 12'h200, PC value after reset
TIMER_DIV, 16, cpu_clk cycles per delay-timer tick (>=2)

Ports:
cpu_clk  in  1  clock
reset  in  1  synchronous, active-high reset
run  in  1  enables issuing new fetches
instr_req  out  1  fetch request
instr_addr  out  ADDR_WIDTH  fetch address (equals pc while instr_req=1)
instr_valid  in  1  instr_data is valid this cycle
instr_data  in  16  instruction word
retire  out  1  high for exactly the EXEC cycle of each instruction
unsup  out  1  high in EXEC when the opcode is unsupported
pc  out  ADDR_WIDTH  current PC
i_reg  out  ADDR_WIDTH  I register
dt  out  8  delay timer
sp  out  $clog2(STACK_DEPTH)+1  stack occupancy
halted  out  1  core in HALT state
fault  out  2  0 none, 1 stack overflow, 2 stack underflow
dbg_addr  in  4  register debug select
dbg_data  out  8  V[dbg_addr], combinational

Behaviour:
- Reset values: state FETCH, pc=PC_RESET, i_reg=0, all V=0, sp=0, dt=0, prescaler=0, fault=0, all pulses/req/halted=0. Reset mid-fetch drops instr_req in the reset cycle and discards any instr_valid in that cycle.
- FSM states: FETCH, EXEC, HALT.
- FETCH:
  - instr_req rises only when run=1.
  - Once high, instr_req and instr_addr are held until instr_valid=1, even if run falls.
  - instr_valid while instr_req=1: capture ir, go to EXEC. instr_valid while instr_req=0 is ignored.
- EXEC (one cycle): retire=1; all writes take effect at the end of the cycle; next state FETCH, or HALT on a fault. Minimum throughput is 2 cycles per instruction (back-to-back valid).
- Default next PC is pc+2.
  - 3xkk / 4xkk / 5xy0 / 9xy0: pc+4 when the skip condition holds.
  - 1nnn: pc=nnn.
  - Bnnn: pc=nnn+V0, truncated.
  - 2nnn: push pc+2, then pc=nnn. If sp==STACK_DEPTH: no push, fault=1, HALT.
  - 00EE: pop into pc. If sp==0: fault=2, HALT.
- Register ops:
  - 6xkk: Vx=kk.
  - 7xkk: Vx=Vx+kk mod 256; VF unchanged.
  - Annn: I=nnn.
  - Fx1E: I=I+Vx, wraps.
- 8xyN ALU ops:
  - N=0/1/2/3: mov/or/and/xor, VF unchanged.
  - N=4: Vx=Vx+Vy, VF=carry.
  - N=5: Vx=Vx-Vy, VF=(Vx>=Vy).
  - N=6: VF=Vx[0], Vx>>=1.
  - N=7: Vx=Vy-Vx, VF=(Vy>=Vx).
  - N=E: VF=Vx[7], Vx<<=1.
  - Other N: unsupported.
  - All flags use operand values from before the write. If x==F, the flag write wins.
- Timers:
  - Fx07: Vx=dt (pre-tick value).
  - Fx15: dt=Vx; wins over a coincident tick.
  - Prescaler counts 0..TIMER_DIV-1 continuously in every state except reset. At wrap, if dt!=0, dt decrements. dt saturates at 0.
- Unsupported (00E0, Cxkk, Dxyn, Exxx, Fx0A/18/29/33/55/65, 0nnn others, malformed 5/9/8): unsup=1, no state change besides pc+2.
- HALT: instr_req=0, halted=1, state frozen except dt. Only reset exits.
- retire and unsup are never high outside EXEC.

Test Plan:
- Reset then run=1, instr_valid at first req with 16'h6A3C -> instr_addr=12'h200; next EXEC V[A]=8'h3C, pc=12'h202, retire pulses once.
- V1=8'hF0, V2=8'h20, execute 8124 -> V1=8'h10, VF=1. Then 8215 -> V2=8'h10, VF=1. Then 8F16 with VF=8'h03 -> VF=1 (flag wins over shift result).
- 2300 at pc=12'h200, then 00EE at 12'h300 -> pc=12'h300, sp=1; then pc=12'h202, sp=0. STACK_DEPTH+1 nested calls -> fault=1, halted=1, instr_req stays 0.
- 3005 with V0=8'h05 at pc=12'h204 -> pc=12'h208. 4005 same -> pc=12'h206. B0FF at V0=8'h02 with ADDR_WIDTH=12 -> pc=12'h101; BFFF with V0=8'h01 -> pc=12'h000 (wrap).
- F315 with V3=8'h03, TIMER_DIV=4 -> dt reads 3,2,1,0 at 4-cycle spacing, then stays 0. F407 after first tick -> V4=8'h02.
- D123 -> unsup=1, pc+2, no register change. Drop run while instr_req=1 -> request held until valid. Assert reset mid-request -> pc=12'h200, instr_req=0 for that cycle.

Source files
------------

// File: rtl/chip8_exec_core.sv
`default_nettype none
// ============================================================================
//  Module   : chip8_exec_core
//  Purpose  : Multi-cycle Chip-8 execution core. Fetches instructions over a
//             valid handshake and executes the non-display, non-keypad subset.
//             Owns PC, I, V0-VF, the call stack and the delay timer.
//  Revision : 1.0  initial release
// ============================================================================
module chip8_exec_core #(
    parameter int                    ADDR_WIDTH  = 12,
    parameter int                    STACK_DEPTH = 16,
    parameter logic [ADDR_WIDTH-1:0] PC_RESET    = 'h200,
    parameter int                    TIMER_DIV   = 16
) (
    input  logic                           cpu_clk,
    input  logic                           reset,
    input  logic                           run,
    output logic                           instr_req,
    output logic [ADDR_WIDTH-1:0]          instr_addr,
    input  logic                           instr_valid,
    input  logic [15:0]                    instr_data,
    output logic                           retire,
    output logic                           unsup,
    output logic [ADDR_WIDTH-1:0]          pc,
    output logic [ADDR_WIDTH-1:0]          i_reg,
    output logic [7:0]                     dt,
    output logic [$clog2(STACK_DEPTH):0]   sp,
    output logic                           halted,
    output logic [1:0]                     fault,
    input  logic [3:0]                     dbg_addr,
    output logic [7:0]                     dbg_data
);

    localparam int c_SP_W = $clog2(STACK_DEPTH) + 1;
    localparam int c_SI_W = $clog2(STACK_DEPTH);
    localparam int c_PS_W = $clog2(TIMER_DIV);
    localparam logic [c_PS_W-1:0] c_PS_MAX = c_PS_W'(TIMER_DIV - 1);

    localparam logic [1:0] c_S_FETCH = 2'd0;
    localparam logic [1:0] c_S_EXEC  = 2'd1;
    localparam logic [1:0] c_S_HALT  = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_i;
    logic [7:0]            r_v [16];
    logic [ADDR_WIDTH-1:0] r_stack [STACK_DEPTH];
    logic [c_SP_W-1:0]     r_sp;
    logic [7:0]            r_dt;
    logic [c_PS_W-1:0]     r_presc;
    logic [1:0]            r_fault;
    logic [15:0]           r_ir;
    logic                  r_pending;

    // Instruction fields and operands
    logic [3:0]            w_op, w_x, w_y, w_n;
    logic [7:0]            w_kk, w_vx, w_vy, w_v0;
    logic [ADDR_WIDTH-1:0] w_nnn, w_pc2, w_pc4, w_stack_top;
    logic [c_SI_W-1:0]     w_push_idx, w_pop_idx;
    logic [8:0]            w_add;

    assign w_op        = r_ir[15:12];
    assign w_x         = r_ir[11:8];
    assign w_y         = r_ir[7:4];
    assign w_n         = r_ir[3:0];
    assign w_kk        = r_ir[7:0];
    assign w_nnn       = ADDR_WIDTH'(r_ir[11:0]);
    assign w_vx        = r_v[w_x];
    assign w_vy        = r_v[w_y];
    assign w_v0        = r_v[0];
    assign w_pc2       = r_pc + ADDR_WIDTH'(2);
    assign w_pc4       = r_pc + ADDR_WIDTH'(4);
    assign w_push_idx  = r_sp[c_SI_W-1:0];
    assign w_pop_idx   = r_sp[c_SI_W-1:0] - c_SI_W'(1);
    assign w_stack_top = r_stack[w_pop_idx];
    assign w_add       = {1'b0, w_vx} + {1'b0, w_vy};

    // Decoded effects of the instruction held in r_ir
    logic                  w_vx_we, w_vf_we, w_i_we, w_dt_load, w_push, w_pop, w_unsup;
    logic [7:0]            w_vx_wd, w_vf_wd;
    logic [ADDR_WIDTH-1:0] w_i_wd, w_pc_next;
    logic [1:0]            w_fault_code;
    logic                  w_tick;

    // Instruction decode: next PC, register/stack/timer writes, fault code
    always_comb begin
        w_pc_next    = w_pc2;
        w_vx_we      = 1'b0;
        w_vx_wd      = 8'h00;
        w_vf_we      = 1'b0;
        w_vf_wd      = 8'h00;
        w_i_we       = 1'b0;
        w_i_wd       = r_i;
        w_dt_load    = 1'b0;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_fault_code = 2'd0;
        w_unsup      = 1'b0;
        case (w_op)
            4'h0: begin
                if (r_ir[11:0] == 12'h0EE) begin
                    if (r_sp == '0) w_fault_code = 2'd2;
                    else begin
                        w_pop     = 1'b1;
                        w_pc_next = w_stack_top;
                    end
                end else w_unsup = 1'b1;
            end
            4'h1: w_pc_next = w_nnn;
            4'h2: begin
                if (r_sp == c_SP_W'(STACK_DEPTH)) w_fault_code = 2'd1;
                else begin
                    w_push    = 1'b1;
                    w_pc_next = w_nnn;
                end
            end
            4'h3: if (w_vx == w_kk) w_pc_next = w_pc4;
            4'h4: if (w_vx != w_kk) w_pc_next = w_pc4;
            4'h5: begin
                if (w_n != 4'h0) w_unsup = 1'b1;
                else if (w_vx == w_vy) w_pc_next = w_pc4;
            end
            4'h6: begin
                w_vx_we = 1'b1;
                w_vx_wd = w_kk;
            end
            4'h7: begin
                w_vx_we = 1'b1;
                w_vx_wd = w_vx + w_kk;
            end
            4'h8: begin
                w_vx_we = 1'b1;
                case (w_n)
                    4'h0: w_vx_wd = w_vy;
                    4'h1: w_vx_wd = w_vx | w_vy;
                    4'h2: w_vx_wd = w_vx & w_vy;
                    4'h3: w_vx_wd = w_vx ^ w_vy;
                    4'h4: begin
                        w_vx_wd = w_add[7:0];
                        w_vf_we = 1'b1;
                        w_vf_wd = {7'd0, w_add[8]};
                    end
                    4'h5: begin
                        w_vx_wd = w_vx - w_vy;
                        w_vf_we = 1'b1;
                        w_vf_wd = {7'd0, (w_vx >= w_vy)};
                    end
                    4'h6: begin
                        w_vx_wd = {1'b0, w_vx[7:1]};
                        w_vf_we = 1'b1;
                        w_vf_wd = {7'd0, w_vx[0]};
                    end
                    4'h7: begin
                        w_vx_wd = w_vy - w_vx;
                        w_vf_we = 1'b1;
                        w_vf_wd = {7'd0, (w_vy >= w_vx)};
                    end
                    4'hE: begin
                        w_vx_wd = {w_vx[6:0], 1'b0};
                        w_vf_we = 1'b1;
                        w_vf_wd = {7'd0, w_vx[7]};
                    end
                    default: begin
                        w_vx_we = 1'b0;
                        w_unsup = 1'b1;
                    end
                endcase
            end
            4'h9: begin
                if (w_n != 4'h0) w_unsup = 1'b1;
                else if (w_vx != w_vy) w_pc_next = w_pc4;
            end
            4'hA: begin
                w_i_we = 1'b1;
                w_i_wd = w_nnn;
            end
            4'hB: w_pc_next = w_nnn + ADDR_WIDTH'(w_v0);
            4'hF: begin
                case (w_kk)
                    8'h07: begin
                        w_vx_we = 1'b1;
                        w_vx_wd = r_dt;
                    end
                    8'h15: w_dt_load = 1'b1;
                    8'h1E: begin
                        w_i_we = 1'b1;
                        w_i_wd = r_i + ADDR_WIDTH'(w_vx);
                    end
                    default: w_unsup = 1'b1;
                endcase
            end
            default: w_unsup = 1'b1;
        endcase
    end

    // FSM state register
    always_ff @(posedge cpu_clk) begin
        if (reset) r_state <= c_S_FETCH;
        else       r_state <= w_state_next;
    end

    // FSM next-state logic; HALT is left only through reset
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_FETCH: if (instr_req && instr_valid) w_state_next = c_S_EXEC;
            c_S_EXEC:  w_state_next = (w_fault_code != 2'd0) ? c_S_HALT : c_S_FETCH;
            c_S_HALT:  w_state_next = c_S_HALT;
            default:   w_state_next = c_S_FETCH;
        endcase
    end

    // FSM outputs; a request once raised is held by r_pending until accepted
    always_comb begin
        instr_req = (r_state == c_S_FETCH) && (run || r_pending) && !reset;
        retire    = (r_state == c_S_EXEC);
        unsup     = (r_state == c_S_EXEC) && w_unsup;
        halted    = (r_state == c_S_HALT);
    end

    // Architectural state update; everything commits at the end of EXEC
    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            r_pc      <= PC_RESET;
            r_i       <= '0;
            r_sp      <= '0;
            r_fault   <= 2'd0;
            r_ir      <= 16'h0000;
            r_pending <= 1'b0;
            for (int k = 0; k < 16; k++) r_v[k] <= 8'h00;
        end else begin
            r_pending <= instr_req && !instr_valid;
            if (instr_req && instr_valid) r_ir <= instr_data;
            if (r_state == c_S_EXEC) begin
                if (w_fault_code != 2'd0) begin
                    r_fault <= w_fault_code;
                end else begin
                    r_pc <= w_pc_next;
                    if (w_push)  r_sp <= r_sp + c_SP_W'(1);
                    if (w_pop)   r_sp <= r_sp - c_SP_W'(1);
                    if (w_i_we)  r_i  <= w_i_wd;
                    if (w_vx_we) r_v[w_x] <= w_vx_wd;
                    // Issued after the Vx write so a flag into VF overrides it
                    if (w_vf_we) r_v[4'hF] <= w_vf_wd;
                end
            end
        end
    end

    // Return-address stack storage; contents need no reset since sp gates use
    always_ff @(posedge cpu_clk) begin
        if (r_state == c_S_EXEC && w_push) r_stack[w_push_idx] <= w_pc2;
    end

    assign w_tick = (r_presc == c_PS_MAX);

    // Delay timer with free-running prescaler; a load beats a coincident tick
    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            r_presc <= '0;
            r_dt    <= 8'h00;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + c_PS_W'(1);
            if (r_state == c_S_EXEC && w_dt_load) r_dt <= w_vx;
            else if (w_tick && r_dt != 8'h00)     r_dt <= r_dt - 8'h01;
        end
    end

    assign instr_addr = r_pc;
    assign pc         = r_pc;
    assign i_reg      = r_i;
    assign dt         = r_dt;
    assign sp         = r_sp;
    assign fault      = r_fault;
    assign dbg_data   = r_v[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_chip8_exec_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_chip8_exec_core
//  Purpose  : Self-checking bench for chip8_exec_core; directed sequences plus
//             randomized instruction streams against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_chip8_exec_core;

    localparam int AW = 12;
    localparam int SD = 16;
    localparam int TD = 4;

    logic          cpu_clk = 1'b0;
    logic          reset = 1'b1;
    logic          run = 1'b0;
    logic          instr_req;
    logic [AW-1:0] instr_addr;
    logic          instr_valid = 1'b0;
    logic [15:0]   instr_data = 16'h0000;
    logic          retire, unsup, halted;
    logic [AW-1:0] pc, i_reg;
    logic [7:0]    dt;
    logic [4:0]    sp;
    logic [1:0]    fault;
    logic [3:0]    dbg_addr = 4'h0;
    logic [7:0]    dbg_data;

    chip8_exec_core #(
        .ADDR_WIDTH (AW),
        .STACK_DEPTH(SD),
        .PC_RESET   (12'h200),
        .TIMER_DIV  (TD)
    ) u_dut (
        .cpu_clk    (cpu_clk),
        .reset      (reset),
        .run        (run),
        .instr_req  (instr_req),
        .instr_addr (instr_addr),
        .instr_valid(instr_valid),
        .instr_data (instr_data),
        .retire     (retire),
        .unsup      (unsup),
        .pc         (pc),
        .i_reg      (i_reg),
        .dt         (dt),
        .sp         (sp),
        .halted     (halted),
        .fault      (fault),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Behavioural model of the architectural state
    logic [11:0] m_pc, m_i;
    logic [7:0]  m_v [16];
    logic [11:0] m_stack [$];
    logic [7:0]  m_dt;
    int          m_fault;
    bit          m_halt;
    int          n_edge;
    int          n_err = 0;
    int          n_chk = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 12'h200;
        m_i = 12'h000;
        for (int k = 0; k < 16; k++) m_v[k] = 8'h00;
        m_stack.delete();
        m_dt = 8'h00;
        m_fault = 0;
        m_halt = 0;
        n_edge = 0;
    endtask

    // One clock edge; the timer divides the count of post-reset edges by TD
    task automatic step(input bit load, input logic [7:0] val);
        @(posedge cpu_clk);
        n_edge++;
        if (load) m_dt = val;
        else if (n_edge % TD == 0 && m_dt != 8'h00) m_dt = m_dt - 8'h01;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run = 1'b0;
        instr_valid = 1'b0;
        @(posedge cpu_clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // Executes one instruction on the model; returns unsup and timer-load info
    task automatic model_exec(input logic [15:0] ins, output bit exp_unsup,
                              output bit load, output logic [7:0] lval);
        int x, y, vx, vy, s;
        logic [11:0] nxt, nnn;
        logic [7:0]  kk;
        x = int'(ins[11:8]);
        y = int'(ins[7:4]);
        vx = int'(m_v[x]);
        vy = int'(m_v[y]);
        kk = ins[7:0];
        nnn = ins[11:0];
        nxt = m_pc + 12'd2;
        exp_unsup = 0;
        load = 0;
        lval = 8'h00;
        case (ins[15:12])
            4'h0: if (ins == 16'h00EE) begin
                      if (m_stack.size() == 0) begin m_fault = 2; m_halt = 1; end
                      else nxt = m_stack.pop_back();
                  end else exp_unsup = 1;
            4'h1: nxt = nnn;
            4'h2: if (m_stack.size() == SD) begin m_fault = 1; m_halt = 1; end
                  else begin m_stack.push_back(nxt); nxt = nnn; end
            4'h3: if (vx == int'(kk)) nxt = m_pc + 12'd4;
            4'h4: if (vx != int'(kk)) nxt = m_pc + 12'd4;
            4'h5: if (ins[3:0] != 0) exp_unsup = 1; else if (vx == vy) nxt = m_pc + 12'd4;
            4'h9: if (ins[3:0] != 0) exp_unsup = 1; else if (vx != vy) nxt = m_pc + 12'd4;
            4'h6: m_v[x] = kk;
            4'h7: m_v[x] = 8'((vx + int'(kk)) % 256);
            4'h8: case (ins[3:0])
                      4'h0: m_v[x] = 8'(vy);
                      4'h1: m_v[x] = 8'(vx | vy);
                      4'h2: m_v[x] = 8'(vx & vy);
                      4'h3: m_v[x] = 8'(vx ^ vy);
                      4'h4: begin s = vx + vy; m_v[x] = 8'(s % 256); m_v[15] = (s > 255) ? 8'd1 : 8'd0; end
                      4'h5: begin m_v[x] = 8'((vx - vy + 256) % 256); m_v[15] = (vx >= vy) ? 8'd1 : 8'd0; end
                      4'h6: begin m_v[x] = 8'(vx / 2); m_v[15] = 8'(vx % 2); end
                      4'h7: begin m_v[x] = 8'((vy - vx + 256) % 256); m_v[15] = (vy >= vx) ? 8'd1 : 8'd0; end
                      4'hE: begin m_v[x] = 8'((vx * 2) % 256); m_v[15] = 8'(vx / 128); end
                      default: exp_unsup = 1;
                  endcase
            4'hA: m_i = nnn;
            4'hB: nxt = 12'((int'(nnn) + int'(m_v[0])) % 4096);
            4'hF: case (kk)
                      8'h07: m_v[x] = m_dt;
                      8'h15: begin load = 1; lval = m_v[x]; end
                      8'h1E: m_i = 12'((int'(m_i) + vx) % 4096);
                      default: exp_unsup = 1;
                  endcase
            default: exp_unsup = 1;
        endcase
        if (!m_halt) m_pc = nxt;
    endtask

    task automatic check_state(input string tag);
        logic [127:0] gv, ev;
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".i"}, i_reg, m_i);
        chk({tag, ".sp"}, sp, m_stack.size());
        chk({tag, ".fault"}, fault, m_fault);
        chk({tag, ".halted"}, halted, m_halt);
        chk({tag, ".dt"}, dt, m_dt);
        for (int k = 0; k < 16; k++) begin
            dbg_addr = 4'(k);
            #0.1;
            gv[k*8 +: 8] = dbg_data;
            ev[k*8 +: 8] = m_v[k];
        end
        chk({tag, ".v"}, gv, ev);
    endtask

    // Fetch (with optional wait cycles and run dropped mid-request) and execute
    task automatic do_instr(input string tag, input logic [15:0] ins,
                            input int delay, input bit drop_run);
        bit eu, ld;
        logic [7:0] lv;
        run = 1'b1;
        #1;
        chk({tag, ".req"}, instr_req, 1'b1);
        chk({tag, ".addr"}, instr_addr, m_pc);
        for (int d = 0; d < delay; d++) begin
            step(0, 8'h00);
            if (drop_run) run = 1'b0;
            #1;
            chk({tag, ".req_hold"}, instr_req, 1'b1);
            chk({tag, ".addr_hold"}, instr_addr, m_pc);
        end
        instr_valid = 1'b1;
        instr_data = ins;
        step(0, 8'h00);
        instr_valid = 1'b0;
        run = 1'b1;
        model_exec(ins, eu, ld, lv);
        chk({tag, ".retire"}, retire, 1'b1);
        chk({tag, ".unsup"}, unsup, eu);
        step(ld, lv);
        chk({tag, ".retire_post"}, retire, 1'b0);
        chk({tag, ".unsup_post"}, unsup, 1'b0);
        check_state(tag);
    endtask

    task automatic idle(input string tag, input int cycles, input bit run_val);
        for (int c = 0; c < cycles; c++) begin
            run = run_val;
            step(0, 8'h00);
            chk({tag, ".dt"}, dt, m_dt);
            chk({tag, ".req"}, instr_req, 1'b0);
            chk({tag, ".halted"}, halted, m_halt);
        end
    endtask

    function automatic logic [15:0] gen_ins();
        logic [15:0] r;
        int sel;
        logic [3:0]  ns [9] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hE};
        logic [7:0]  fs [3] = '{8'h07, 8'h15, 8'h1E};
        r = 16'($urandom);
        sel = $urandom_range(0, 9);
        case (r[15:12])
            4'h0: if (m_stack.size() > 0 && sel < 6) r = 16'h00EE;
                  else if (sel < 8 || r == 16'h00EE) r = 16'h00E0;
            4'h2: if (m_stack.size() == SD) r = {4'h6, r[11:0]};
            4'h5, 4'h9: if (sel < 8) r[3:0] = 4'h0;
            4'h8: if (sel < 8) r[3:0] = ns[$urandom_range(0, 8)];
            4'hF: if (sel < 8) r[7:0] = fs[$urandom_range(0, 2)];
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        model_reset();
        do_reset();
        do_reset();
        chk("reset.req_run0", instr_req, 1'b0);
        check_state("reset");

        // Load immediate, ALU flags, flag-over-result into VF
        do_instr("ld6A", 16'h6A3C, 0, 0);
        do_instr("ld61", 16'h61F0, 0, 0);
        do_instr("ld62", 16'h6220, 1, 0);
        do_instr("add", 16'h8124, 0, 0);
        do_instr("sub", 16'h8215, 0, 0);
        do_instr("ld6F", 16'h6F03, 0, 0);
        do_instr("shrF", 16'h8F16, 0, 0);
        do_instr("shl", 16'h812E, 0, 0);
        do_instr("subn", 16'h8127, 0, 0);

        // Call / return
        do_reset();
        do_instr("call", 16'h2300, 0, 0);
        do_instr("ret", 16'h00EE, 0, 0);

        // Skips and computed jumps with address wrap
        do_instr("ld0", 16'h6005, 0, 0);
        do_instr("se", 16'h3005, 0, 0);
        do_instr("sne", 16'h4005, 0, 0);
        do_instr("se5", 16'h5000, 0, 0);
        do_instr("sne9", 16'h9010, 0, 0);
        do_instr("ld0b", 16'h6002, 0, 0);
        do_instr("jp0", 16'hB0FF, 0, 0);
        do_instr("ld0c", 16'h6001, 0, 0);
        do_instr("jpwrap", 16'hBFFF, 0, 0);
        do_instr("ldi", 16'hAFFE, 0, 0);
        do_instr("addi", 16'hF01E, 0, 0);

        // Delay timer load, countdown, saturation, and read
        do_reset();
        do_instr("ld3", 16'h6303, 0, 0);
        do_instr("ldt", 16'hF315, 0, 0);
        idle("timer", 18, 0);
        do_reset();
        do_instr("ld3b", 16'h6303, 0, 0);
        do_instr("ldtb", 16'hF315, 0, 0);
        idle("tmr2", 3, 0);
        do_instr("rdt", 16'hF407, 0, 0);

        // Unsupported opcode, request hold with run dropped
        do_instr("unsupD", 16'hD123, 0, 0);
        do_instr("unsup8", 16'h8128, 0, 0);
        do_instr("hold", 16'h6B77, 3, 1);

        // Reset mid-request discards the instruction presented in that cycle
        run = 1'b1;
        #1;
        chk("rstmid.req_before", instr_req, 1'b1);
        reset = 1'b1;
        instr_valid = 1'b1;
        instr_data = 16'h6A55;
        #1;
        chk("rstmid.req_in_reset", instr_req, 1'b0);
        @(posedge cpu_clk);
        #1;
        reset = 1'b0;
        instr_valid = 1'b0;
        model_reset();
        check_state("rstmid");
        do_instr("rstmid_next", 16'h6100, 0, 0);

        // Stack overflow halts with request held low
        do_reset();
        for (int k = 0; k <= SD; k++) do_instr("nest", 16'h2400 + 16'(k * 2), 0, 0);
        idle("ovf_halt", 6, 1);

        // Underflow
        do_reset();
        do_instr("udf", 16'h00EE, 0, 0);
        idle("udf_halt", 4, 1);

        // Randomized instruction stream
        for (int s = 0; s < 3; s++) begin
            do_reset();
            for (int k = 0; k < 100; k++) begin
                if (m_halt) break;
                do_instr("rnd", gen_ins(), $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
